// File: rtl/sccpu_trace_pkg.sv
// ---------------------------------------------------------------------------
// sccpu_trace_pkg
// Shared definitions for the single-cycle CPU trace capture block:
//   - capture session state encoding
//   - record width and word slicing of a packed {pc, inst, alu} record
//   - serializer beat-index encoding
//   - drop counter width
// ---------------------------------------------------------------------------
package sccpu_trace_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    localparam int WORD_W = 32;
    localparam int REC_W  = 96;
    localparam int DROP_W = 16;

    // Beat index within a record; also selects the record word on the bus.
    localparam logic [1:0] BEAT_PC   = 2'd0;
    localparam logic [1:0] BEAT_INST = 2'd1;
    localparam logic [1:0] BEAT_ALU  = 2'd2;

endpackage

// File: rtl/trace_fifo.sv
// ---------------------------------------------------------------------------
// trace_fifo
// Synchronous record FIFO with a registered head-of-queue output.
//   clk        : clock
//   rst        : synchronous active-high reset (pointers and occupancy)
//   push       : request to write push_data
//   push_data  : record to write
//   pop        : remove the current head (ignored when empty)
//   head       : registered copy of the oldest record (valid when !empty)
//   full/empty : occupancy flags
//   push_ok    : push accepted this cycle (a pop frees room in a full FIFO)
// DEPTH must be a power of two >= 2 so pointers wrap naturally.
// ---------------------------------------------------------------------------
module trace_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 96
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic             push_ok
);

    localparam int             AW       = $clog2(DEPTH);
    localparam logic [AW:0]    FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    rd_ptr_nxt;
    logic [AW:0]      count;
    logic             pop_ok;

    assign full       = (count == FULL_CNT);
    assign empty      = (count == '0);
    assign pop_ok     = pop && !empty;
    assign push_ok    = push && (!full || pop_ok);
    assign rd_ptr_nxt = pop_ok ? rd_ptr + 1'b1 : rd_ptr;

    // Storage: data only, never reset.
    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + 1'b1;
            rd_ptr <= rd_ptr_nxt;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // Head register tracks mem[rd_ptr] one edge ahead. When the slot that
    // becomes the head is the one being written this edge (FIFO empty, or
    // draining its last entry), the incoming record is forwarded directly.
    always_ff @(posedge clk) begin
        if (rst)
            head <= '0;
        else if (push_ok && (rd_ptr_nxt == wr_ptr))
            head <= push_data;
        else
            head <= mem[rd_ptr_nxt];
    end

endmodule

// File: rtl/trace_capture.sv
// ---------------------------------------------------------------------------
// trace_capture
// Captures {pc, inst, alu_result} once per cycle starting at a trigger PC,
// buffers records in trace_fifo and serializes each record as three 32-bit
// beats (PC, Inst, Alu_Result) on a valid/ready stream.
//   clock       : clock
//   reset       : synchronous active-high reset
//   arm         : one-cycle pulse, starts a session (IDLE/DONE only)
//   trig_pc     : PC value that starts capture
//   pc/inst/alu_result : CPU state sampled every cycle
//   out_data    : current beat
//   out_valid   : out_data holds a beat
//   out_ready   : downstream accepts the beat
//   out_last    : third (Alu_Result) beat of a record
//   busy        : session active or records still buffered
//   done        : session finished
//   drop_count  : samples lost to a full FIFO (saturating)
// ---------------------------------------------------------------------------
module trace_capture #(
    parameter int DEPTH       = 16,
    parameter int MAX_SAMPLES = 64
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        arm,
    input  logic [31:0] trig_pc,
    input  logic [31:0] pc,
    input  logic [31:0] inst,
    input  logic [31:0] alu_result,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_last,
    output logic        busy,
    output logic        done,
    output logic [15:0] drop_count
);

    import sccpu_trace_pkg::*;

    localparam int                CNT_W     = $clog2(MAX_SAMPLES + 1);
    localparam logic [CNT_W-1:0]  LAST_SMPL = CNT_W'(MAX_SAMPLES - 1);

    function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    state_t            state;
    logic [CNT_W-1:0]  sample_cnt;
    logic [1:0]        beat_idx;
    logic              arm_ok;
    logic              sample_vld;
    logic              push_ok;
    logic              fifo_full;
    logic              fifo_empty;
    logic              beat_xfer;
    logic              pop;
    logic [REC_W-1:0]  head;
    logic [REC_W-1:0]  rec_in;

    // ---- sample stage: decide whether this cycle is recorded ----
    assign arm_ok     = arm && ((state == ST_IDLE) || (state == ST_DONE));
    assign sample_vld = (state == ST_CAPTURE) ||
                        ((state == ST_ARMED) && (pc == trig_pc));
    assign rec_in     = {pc, inst, alu_result};

    trace_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (REC_W)
    ) u_fifo (
        .clk       (clock),
        .rst       (reset),
        .push      (sample_vld),
        .push_data (rec_in),
        .pop       (pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .push_ok   (push_ok)
    );

    // ---- serializer stage: head record split into three beats ----
    // Outputs decode only registered state, so they cannot change while a
    // beat is stalled and the next record appears right after a pop.
    assign out_valid = !fifo_empty;
    assign beat_xfer = out_valid && out_ready;
    assign pop       = beat_xfer && (beat_idx == BEAT_ALU);
    assign out_last  = out_valid && (beat_idx == BEAT_ALU);
    assign busy      = (state == ST_ARMED) || (state == ST_CAPTURE) || !fifo_empty;
    assign done      = (state == ST_DONE);

    always_comb begin
        out_data = '0;
        if (out_valid) begin
            case (beat_idx)
                BEAT_PC:   out_data = head[REC_W-1 -: WORD_W];
                BEAT_INST: out_data = head[REC_W-WORD_W-1 -: WORD_W];
                default:   out_data = head[WORD_W-1:0];
            endcase
        end
    end

    // ---- control: session FSM, sample/drop counters, beat index ----
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= ST_IDLE;
            sample_cnt <= '0;
            drop_count <= '0;
            beat_idx   <= BEAT_PC;
        end else begin
            if (beat_xfer)
                beat_idx <= (beat_idx == BEAT_ALU) ? BEAT_PC : beat_idx + 1'b1;

            if (sample_vld && !push_ok)
                drop_count <= sat_inc(drop_count);

            case (state)
                ST_IDLE, ST_DONE: begin
                    if (arm_ok) begin
                        state      <= ST_ARMED;
                        sample_cnt <= '0;
                        drop_count <= '0;
                    end
                end
                ST_ARMED, ST_CAPTURE: begin
                    // The trigger cycle counts as sample 1; the edge that
                    // records the final sample also ends the session.
                    if (sample_vld) begin
                        sample_cnt <= sample_cnt + 1'b1;
                        state      <= (sample_cnt == LAST_SMPL) ? ST_DONE : ST_CAPTURE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_trace_capture.sv
module tb_trace_capture;

    logic        clock = 1'b0;
    logic        reset;
    logic        arm;
    logic [31:0] trig_pc;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] alu_result;
    logic        out_ready;

    // DEPTH=16 instance
    logic [31:0] s_data;
    logic        s_valid, s_last, s_busy, s_done;
    logic [15:0] s_drop;
    // DEPTH=64 instance (deep enough that a full session never drops)
    logic [31:0] b_data;
    logic        b_valid, b_last, b_busy, b_done;
    logic [15:0] b_drop;

    int checks   = 0;
    int failures = 0;

    logic [32:0] got_s[$];
    logic [32:0] got_b[$];

    always #5 clock = ~clock;

    trace_capture #(.DEPTH(16), .MAX_SAMPLES(64)) u_dut (
        .clock(clock), .reset(reset), .arm(arm), .trig_pc(trig_pc),
        .pc(pc), .inst(inst), .alu_result(alu_result),
        .out_data(s_data), .out_valid(s_valid), .out_ready(out_ready),
        .out_last(s_last), .busy(s_busy), .done(s_done), .drop_count(s_drop)
    );

    trace_capture #(.DEPTH(64), .MAX_SAMPLES(64)) u_big (
        .clock(clock), .reset(reset), .arm(arm), .trig_pc(trig_pc),
        .pc(pc), .inst(inst), .alu_result(alu_result),
        .out_data(b_data), .out_valid(b_valid), .out_ready(out_ready),
        .out_last(b_last), .busy(b_busy), .done(b_done), .drop_count(b_drop)
    );

    function automatic logic [31:0] inst_of(input logic [31:0] p);
        return p ^ 32'hDEAD_0000;
    endfunction

    function automatic logic [31:0] alu_of(input logic [31:0] p);
        return p + 32'h0001_0000;
    endfunction

    // 1 when record r of q is not {p, inst_of(p), alu_of(p)} with last on beat 3
    function automatic int rec_bad(input logic [32:0] q[$], input int r, input logic [31:0] p);
        if (q.size() < 3*r + 3) return 1;
        if (q[3*r] !== {1'b0, p}) return 1;
        if (q[3*r+1] !== {1'b0, inst_of(p)}) return 1;
        if (q[3*r+2] !== {1'b1, alu_of(p)}) return 1;
        return 0;
    endfunction

    // Records beats that transfer at the coming edge, advances one cycle,
    // then steps the CPU model (PC += 4).
    task automatic tick();
        if (s_valid && out_ready) got_s.push_back({s_last, s_data});
        if (b_valid && out_ready) got_b.push_back({b_last, b_data});
        @(posedge clock);
        #1;
        pc         = pc + 32'd4;
        inst       = inst_of(pc);
        alu_result = alu_of(pc);
    endtask

    task automatic set_pc(input logic [31:0] p);
        pc         = p;
        inst       = inst_of(p);
        alu_result = alu_of(p);
    endtask

    task automatic wait_idle(input int bound, output int n);
        n = 0;
        while (!(!s_busy && !b_busy) && n < bound) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        int n;
        reset = 1'b1; arm = 1'b1; out_ready = 1'b1; trig_pc = 32'h0;
        set_pc(32'h0);
        repeat (3) tick();
        checks++; if (s_valid !== 1'b0) begin failures++; $display("FAIL rst_valid: got %0b expected 0", s_valid); end
        checks++; if (s_data !== 32'h0) begin failures++; $display("FAIL rst_data: got %0h expected 0", s_data); end
        checks++; if (s_last !== 1'b0) begin failures++; $display("FAIL rst_last: got %0b expected 0", s_last); end
        checks++; if (s_done !== 1'b0) begin failures++; $display("FAIL rst_done: got %0b expected 0", s_done); end
        checks++; if (s_drop !== 16'h0) begin failures++; $display("FAIL rst_drop: got %0h expected 0", s_drop); end
        checks++; if (s_busy !== 1'b0) begin failures++; $display("FAIL rst_arm_ignored: busy got %0b expected 0", s_busy); end
        reset = 1'b0; arm = 1'b0;
        tick();
        checks++; if (b_busy !== 1'b0) begin failures++; $display("FAIL rst_idle_after: busy got %0b expected 0", b_busy); end
        n = 0;
        got_s.delete(); got_b.delete();
    endtask

    task automatic test_trigger();
        int n;
        out_ready = 1'b1;
        trig_pc   = 32'h0000_0008;
        set_pc(32'h0);
        arm = 1'b1;
        tick();             // arm accepted with pc=0
        arm = 1'b0;
        tick();             // armed, pc=4 no match; pc=8 now presented
        checks++; if (b_valid !== 1'b0) begin failures++; $display("FAIL trig_latency_pre: valid got %0b expected 0", b_valid); end
        tick();             // pc=8 recorded
        checks++; if (b_valid !== 1'b1 || b_data !== 32'h8) begin failures++; $display("FAIL trig_first_present: valid %0b data %0h expected 1 8", b_valid, b_data); end
        n = 0;
        while (got_b.size() < 3 && n < 20) begin tick(); n++; end
        checks++; if (got_b.size() < 3) begin failures++; $display("FAIL trig_timeout: beats got %0d expected 3", got_b.size()); end
        else begin
            checks++; if (got_b[0] !== {1'b0, 32'h8}) begin failures++; $display("FAIL trig_beat1: got %0h expected %0h", got_b[0], {1'b0, 32'h8}); end
            checks++; if (got_b[1] !== {1'b0, inst_of(32'h8)}) begin failures++; $display("FAIL trig_beat2: got %0h expected %0h", got_b[1], {1'b0, inst_of(32'h8)}); end
            checks++; if (got_b[2] !== {1'b1, alu_of(32'h8)}) begin failures++; $display("FAIL trig_beat3: got %0h expected %0h", got_b[2], {1'b1, alu_of(32'h8)}); end
        end
        checks++; if (got_s.size() < 3 || got_s[0] !== {1'b0, 32'h8}) begin failures++; $display("FAIL trig_small_beat1: size %0d expected first beat 8", got_s.size()); end
    endtask

    task automatic test_full_length();
        int n, bad;
        n = 0;
        while (!(b_done && !b_busy && !s_busy) && n < 400) begin tick(); n++; end
        checks++; if (n >= 400) begin failures++; $display("FAIL full_timeout: cycles %0d limit 400", n); end
        checks++; if (got_b.size() !== 192) begin failures++; $display("FAIL full_beats: got %0d expected 192", got_b.size()); end
        bad = 0;
        for (int r = 0; r < 64; r++) bad += rec_bad(got_b, r, 32'h8 + 32'(4*r));
        checks++; if (bad !== 0) begin failures++; $display("FAIL full_content: bad records %0d expected 0", bad); end
        checks++; if (b_done !== 1'b1) begin failures++; $display("FAIL full_done: got %0b expected 1", b_done); end
        checks++; if (b_drop !== 16'd0) begin failures++; $display("FAIL full_drop: got %0d expected 0", b_drop); end
        got_s.delete(); got_b.delete();
    endtask

    task automatic test_overflow();
        int n, bad;
        logic [31:0] t;
        out_ready = 1'b0;
        t = pc + 32'd12;
        trig_pc = t;
        arm = 1'b1; tick(); arm = 1'b0;
        n = 0;
        while (!s_done && n < 200) begin tick(); n++; end
        repeat (3) tick();
        checks++; if (s_drop !== 16'd48) begin failures++; $display("FAIL ovf_drop: got %0d expected 48", s_drop); end
        checks++; if (b_drop !== 16'd0) begin failures++; $display("FAIL ovf_deep_drop: got %0d expected 0", b_drop); end
        checks++; if (s_busy !== 1'b1 || s_done !== 1'b1) begin failures++; $display("FAIL ovf_busy_done: busy %0b done %0b expected 1 1", s_busy, s_done); end
        checks++; if (s_valid !== 1'b1 || s_data !== t) begin failures++; $display("FAIL ovf_head: valid %0b data %0h expected 1 %0h", s_valid, s_data, t); end
        out_ready = 1'b1;
        n = 0;
        while (s_busy && n < 100) begin tick(); n++; end
        checks++; if (got_s.size() !== 48) begin failures++; $display("FAIL ovf_drain_beats: got %0d expected 48", got_s.size()); end
        bad = 0;
        for (int r = 0; r < 16; r++) bad += rec_bad(got_s, r, t + 32'(4*r));
        checks++; if (bad !== 0) begin failures++; $display("FAIL ovf_drain_content: bad records %0d expected 0", bad); end
        checks++; if (s_busy !== 1'b0) begin failures++; $display("FAIL ovf_busy_end: got %0b expected 0", s_busy); end
        wait_idle(400, n);
        checks++; if (got_b.size() !== 192) begin failures++; $display("FAIL ovf_deep_beats: got %0d expected 192", got_b.size()); end
        got_s.delete(); got_b.delete();
    endtask

    task automatic test_backpressure();
        int n, bad_s, bad_b, stall_bad;
        logic pat [4];
        logic st_s, st_b, sl, bl;
        logic [31:0] sd, bd, t, prev, p;
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        t = pc + 32'd12;
        trig_pc = t;
        out_ready = 1'b1;
        arm = 1'b1; tick(); arm = 1'b0;
        n = 0; stall_bad = 0;
        while (!(s_done && !s_busy && b_done && !b_busy) && n < 3000) begin
            out_ready = pat[n % 4];
            st_s = s_valid && !out_ready; sd = s_data; sl = s_last;
            st_b = b_valid && !out_ready; bd = b_data; bl = b_last;
            tick();
            if (st_s && (s_valid !== 1'b1 || s_data !== sd || s_last !== sl)) stall_bad++;
            if (st_b && (b_valid !== 1'b1 || b_data !== bd || b_last !== bl)) stall_bad++;
            n++;
        end
        checks++; if (n >= 3000) begin failures++; $display("FAIL bp_timeout: cycles %0d limit 3000", n); end
        checks++; if (stall_bad !== 0) begin failures++; $display("FAIL bp_stall_stable: unstable cycles %0d expected 0", stall_bad); end
        bad_s = (got_s.size() % 3 != 0) ? 1 : 0;
        prev = t - 32'd4;
        for (int r = 0; r < got_s.size() / 3; r++) begin
            p = got_s[3*r][31:0];
            bad_s += rec_bad(got_s, r, p);
            if (p <= prev || p > t + 32'd252 || p[1:0] != 2'b00) bad_s++;
            if (r == 0 && p !== t) bad_s++;
            prev = p;
        end
        checks++; if (bad_s !== 0) begin failures++; $display("FAIL bp_small_scoreboard: errors %0d expected 0", bad_s); end
        checks++; if (got_s.size() / 3 + int'(s_drop) !== 64) begin failures++; $display("FAIL bp_small_accounting: records+drops %0d expected 64", got_s.size() / 3 + int'(s_drop)); end
        bad_b = (got_b.size() % 3 != 0) ? 1 : 0;
        prev = t - 32'd4;
        for (int r = 0; r < got_b.size() / 3; r++) begin
            p = got_b[3*r][31:0];
            bad_b += rec_bad(got_b, r, p);
            if (p <= prev || p > t + 32'd252 || p[1:0] != 2'b00) bad_b++;
            if (r == 0 && p !== t) bad_b++;
            prev = p;
        end
        checks++; if (bad_b !== 0) begin failures++; $display("FAIL bp_deep_scoreboard: errors %0d expected 0", bad_b); end
        checks++; if (got_b.size() / 3 + int'(b_drop) !== 64) begin failures++; $display("FAIL bp_deep_accounting: records+drops %0d expected 64", got_b.size() / 3 + int'(b_drop)); end
        got_s.delete(); got_b.delete();
    endtask

    task automatic test_reset_mid();
        int n;
        logic [31:0] t;
        out_ready = 1'b1;
        trig_pc = pc + 32'd12;
        arm = 1'b1; tick(); arm = 1'b0;
        n = 0;
        while (got_s.size() < 2 && n < 50) begin tick(); n++; end
        checks++; if (got_s.size() !== 2) begin failures++; $display("FAIL rmid_setup: beats got %0d expected 2", got_s.size()); end
        reset = 1'b1;
        tick();
        checks++; if (s_valid !== 1'b0 || b_valid !== 1'b0) begin failures++; $display("FAIL rmid_valid: got %0b/%0b expected 0/0", s_valid, b_valid); end
        checks++; if (s_data !== 32'h0 || s_last !== 1'b0) begin failures++; $display("FAIL rmid_data: data %0h last %0b expected 0 0", s_data, s_last); end
        checks++; if (s_busy !== 1'b0 || s_done !== 1'b0) begin failures++; $display("FAIL rmid_state: busy %0b done %0b expected 0 0", s_busy, s_done); end
        reset = 1'b0;
        got_s.delete(); got_b.delete();
        t = pc + 32'd12;
        trig_pc = t;
        arm = 1'b1; tick(); arm = 1'b0;
        n = 0;
        while (got_s.size() < 1 && n < 50) begin tick(); n++; end
        checks++; if (got_s.size() < 1 || got_s[0] !== {1'b0, t}) begin failures++; $display("FAIL rmid_clean_first: size %0d expected first beat %0h", got_s.size(), t); end
        n = 0;
        while (!(s_done && b_done) && n < 200) begin tick(); n++; end
        wait_idle(600, n);
        checks++; if (s_busy !== 1'b0 || b_busy !== 1'b0) begin failures++; $display("FAIL rmid_idle: busy %0b/%0b expected 0/0", s_busy, b_busy); end
        got_s.delete(); got_b.delete();
    endtask

    task automatic test_rearm();
        int n, bad;
        logic [31:0] t_old, t_new;
        out_ready = 1'b0;
        t_old = pc + 32'd12;
        trig_pc = t_old;
        arm = 1'b1; tick(); arm = 1'b0;
        n = 0;
        while (!s_done && n < 200) begin tick(); n++; end
        checks++; if (s_drop !== 16'd48) begin failures++; $display("FAIL rearm_pre_drop: got %0d expected 48", s_drop); end
        out_ready = 1'b1;
        t_new = pc + 32'd56;
        trig_pc = t_new;
        arm = 1'b1; tick(); arm = 1'b0;
        checks++; if (s_drop !== 16'd0) begin failures++; $display("FAIL rearm_drop_clear: got %0d expected 0", s_drop); end
        checks++; if (s_done !== 1'b0 || s_busy !== 1'b1) begin failures++; $display("FAIL rearm_state: done %0b busy %0b expected 0 1", s_done, s_busy); end
        n = 0;
        while (!(s_done && !s_busy && b_done && !b_busy) && n < 2000) begin tick(); n++; end
        checks++; if (n >= 2000) begin failures++; $display("FAIL rearm_timeout: cycles %0d limit 2000", n); end
        bad = 0;
        for (int r = 0; r < 16; r++) bad += rec_bad(got_s, r, t_old + 32'(4*r));
        checks++; if (bad !== 0) begin failures++; $display("FAIL rearm_old_drain: bad records %0d expected 0", bad); end
        checks++; if (rec_bad(got_s, 16, t_new) !== 0) begin failures++; $display("FAIL rearm_new_first: size %0d expected record pc %0h", got_s.size(), t_new); end
        got_s.delete(); got_b.delete();
    endtask

    initial begin
        reset = 1'b1; arm = 1'b0; out_ready = 1'b0; trig_pc = '0;
        set_pc(32'h0);
        #1;
        test_reset();
        test_trigger();
        test_full_length();
        test_overflow();
        test_backpressure();
        test_reset_mid();
        test_rearm();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
